// File: rtl/adc_max_readout_ctrl_pkg.sv
// adc_max_readout_ctrl_pkg: shared FSM encoding, counter width and index-width helper
package adc_max_readout_ctrl_pkg;
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_SCAN = 1'b1;
  localparam int WIN_CNT_W = 16;
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/adc_max_readout_ctrl_if.sv
// adc_max_readout_ctrl_if: {core, max} record valid/ready port (rec_ovr only with ADC_MAX_OVR_FLAG_EN)
interface adc_max_readout_ctrl_if
  import adc_max_readout_ctrl_pkg::*;
#(
  parameter int ADC_DATA_WIDTH = 8,
  parameter int NUM_CORES = 4
);
  logic rec_valid;
  logic rec_ready;
  logic [idx_w(NUM_CORES)-1:0] rec_core;
  logic [ADC_DATA_WIDTH-1:0] rec_max;
  logic rec_last;
`ifdef ADC_MAX_OVR_FLAG_EN
  logic rec_ovr;
  modport master(output rec_valid, rec_core, rec_max, rec_last, rec_ovr, input rec_ready);
  modport slave(input rec_valid, rec_core, rec_max, rec_last, rec_ovr, output rec_ready);
`else
  modport master(output rec_valid, rec_core, rec_max, rec_last, input rec_ready);
  modport slave(input rec_valid, rec_core, rec_max, rec_last, output rec_ready);
`endif
endinterface

// File: rtl/adc_max_win_timer.sv
// adc_max_win_timer: detection-window counter, window strobe and first-window suppression
module adc_max_win_timer #(
  parameter int WINDOW_CYCLES = 150000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en_i,
  output logic win_start_o,
  output logic arm_o
);
  localparam int CW = $clog2(WINDOW_CYCLES);
  logic [CW-1:0] cnt;
  logic first;
  assign win_start_o = en_i && cnt == '0;
  assign arm_o = win_start_o && !first;
  // count while enabled; a disabled window re-arms the partial-window flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      first <= 1'b1;
    end else begin
      cnt <= (!en_i || cnt == CW'(WINDOW_CYCLES - 1)) ? '0 : cnt + 1'b1;
      first <= !en_i ? 1'b1 : (win_start_o ? 1'b0 : first);
    end
  end
endmodule

// File: rtl/delay_line.sv
// delay_line: fixed-depth register pipeline
module delay_line #(
  parameter int DATA_WIDTH = 1,
  parameter int PIPELINE_DEPTH = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout
);
  logic [DATA_WIDTH-1:0] pipe [PIPELINE_DEPTH];
  assign dout = pipe[PIPELINE_DEPTH-1];
  // shift din through PIPELINE_DEPTH stages
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < PIPELINE_DEPTH; i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= din;
      for (int i = 1; i < PIPELINE_DEPTH; i++) pipe[i] <= pipe[i-1];
    end
  end
endmodule

// File: rtl/adc_max_readout_ctrl.sv
// adc_max_readout_ctrl: window sequencer, snapshot bank and record drain (option ADC_MAX_OVR_FLAG_EN)
module adc_max_readout_ctrl
  import adc_max_readout_ctrl_pkg::*;
#(
  parameter int ADC_DATA_WIDTH = 8,
  parameter int NUM_CORES = 4,
  parameter int WINDOW_CYCLES = 150000,
  parameter int CAP_DELAY = 5
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en_i,
  input  logic clr_i,
  input  logic [NUM_CORES*ADC_DATA_WIDTH-1:0] adc_max_i,
  input  logic [ADC_DATA_WIDTH-1:0] ovr_thresh_i,
  output logic win_start_o,
  adc_max_readout_ctrl_if.master rec,
  output logic [ADC_DATA_WIDTH-1:0] peak_o,
  output logic [WIN_CNT_W-1:0] win_cnt_o,
`ifdef ADC_MAX_OVR_FLAG_EN
  output logic [WIN_CNT_W-1:0] ovr_win_cnt_o,
`endif
  output logic overrun_o
);
  localparam int IW = idx_w(NUM_CORES);
  logic arm, dly, snap, take, accept;
  logic [0:0] state;
  logic [IW-1:0] idx;
  logic [ADC_DATA_WIDTH-1:0] bank [NUM_CORES];
  logic [ADC_DATA_WIDTH-1:0] run_peak, nxt_peak;
  adc_max_win_timer #(.WINDOW_CYCLES(WINDOW_CYCLES)) u_timer (
    .clk(clk), .rst_n(rst_n), .en_i(en_i), .win_start_o(win_start_o), .arm_o(arm)
  );
  delay_line #(.DATA_WIDTH(1), .PIPELINE_DEPTH(CAP_DELAY)) u_dly (
    .clk(clk), .rst_n(rst_n), .din(arm), .dout(dly)
  );
  assign snap = dly && en_i;
  assign take = snap && state == ST_IDLE;
  assign rec.rec_valid = state == ST_SCAN;
  assign rec.rec_core = idx;
  assign rec.rec_max = bank[idx];
  assign rec.rec_last = idx == IW'(NUM_CORES - 1);
  assign accept = rec.rec_valid && rec.rec_ready;
  assign nxt_peak = rec.rec_max > run_peak ? rec.rec_max : run_peak;
  // snapshot on the delayed strobe, drain one record per accept, publish peak on the last one
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      idx <= '0;
      run_peak <= '0;
      peak_o <= '0;
      win_cnt_o <= '0;
      overrun_o <= 1'b0;
      for (int k = 0; k < NUM_CORES; k++) bank[k] <= '0;
    end else begin
      if (snap) win_cnt_o <= win_cnt_o + 1'b1;
      overrun_o <= (snap && state == ST_SCAN) ? 1'b1 : (clr_i ? 1'b0 : overrun_o);
      if (take) begin
        state <= ST_SCAN;
        idx <= '0;
        run_peak <= '0;
        for (int k = 0; k < NUM_CORES; k++) bank[k] <= adc_max_i[k*ADC_DATA_WIDTH +: ADC_DATA_WIDTH];
      end else if (accept) begin
        idx <= idx + 1'b1;
        run_peak <= nxt_peak;
        if (rec.rec_last) begin
          state <= ST_IDLE;
          peak_o <= nxt_peak;
        end
      end
    end
  end
`ifdef ADC_MAX_OVR_FLAG_EN
  logic any_ovr;
  assign rec.rec_ovr = rec.rec_max >= ovr_thresh_i;
  // count drained snapshots that held at least one over-range record, saturating
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      any_ovr <= 1'b0;
      ovr_win_cnt_o <= '0;
    end else begin
      any_ovr <= take ? 1'b0 : (accept && rec.rec_ovr) ? 1'b1 : any_ovr;
      if (accept && rec.rec_last && (any_ovr || rec.rec_ovr) && ovr_win_cnt_o != '1)
        ovr_win_cnt_o <= ovr_win_cnt_o + 1'b1;
      else if (clr_i)
        ovr_win_cnt_o <= '0;
    end
  end
`else
  logic unused_thresh;
  assign unused_thresh = ^ovr_thresh_i;
`endif
endmodule

// File: tb/tb_adc_max_readout_ctrl.sv
// tb_adc_max_readout_ctrl: directed scenario bench for the readout sequencer
module tb_adc_max_readout_ctrl;
  localparam int W = 8;
  localparam int NC = 4;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en_i = 1'b0;
  logic clr_i = 1'b0;
  logic [NC*W-1:0] adc_max_i = '0;
  logic [W-1:0] ovr_thresh_i = 8'd100;
  logic win_start_o;
  logic [W-1:0] peak_o;
  logic [15:0] win_cnt_o;
  logic overrun_o;
`ifdef ADC_MAX_OVR_FLAG_EN
  logic [15:0] ovr_win_cnt_o;
`endif
  logic [W-1:0] lanes [NC];
  int checks = 0;
  int errors = 0;
  int cyc = 0;

  adc_max_readout_ctrl_if #(.ADC_DATA_WIDTH(W), .NUM_CORES(NC)) rif ();

  adc_max_readout_ctrl #(
    .ADC_DATA_WIDTH(W), .NUM_CORES(NC), .WINDOW_CYCLES(32), .CAP_DELAY(5)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en_i(en_i), .clr_i(clr_i), .adc_max_i(adc_max_i),
    .ovr_thresh_i(ovr_thresh_i), .win_start_o(win_start_o), .rec(rif),
    .peak_o(peak_o), .win_cnt_o(win_cnt_o),
`ifdef ADC_MAX_OVR_FLAG_EN
    .ovr_win_cnt_o(ovr_win_cnt_o),
`endif
    .overrun_o(overrun_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic wait_to(input int t);
    while (cyc < t) tick();
  endtask

  task automatic set_lanes(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] c, input logic [W-1:0] d);
    lanes[0] = a; lanes[1] = b; lanes[2] = c; lanes[3] = d;
    adc_max_i = {d, c, b, a};
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    rif.rec_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (rif.rec_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", rif.rec_valid); end
    checks++; if (peak_o !== 8'd0) begin errors++; $display("FAIL reset_peak got %0d exp 0", peak_o); end
    checks++; if (win_cnt_o !== 16'd0) begin errors++; $display("FAIL reset_wincnt got %0d exp 0", win_cnt_o); end
    checks++; if (overrun_o !== 1'b0) begin errors++; $display("FAIL reset_overrun got %b exp 0", overrun_o); end
    rst_n = 1'b1;
    tick();
    tick();
    checks++; if (win_start_o !== 1'b0) begin errors++; $display("FAIL idle_strobe got %b exp 0", win_start_o); end
  endtask

  task automatic test_basic();
    int bad = 0;
    set_lanes(8'd10, 8'd200, 8'd7, 8'd55);
    en_i = 1'b1;
    cyc = 0;
    #1;
    checks++; if (win_start_o !== 1'b1) begin errors++; $display("FAIL first_strobe got %b exp 1", win_start_o); end
    while (cyc < 38) begin
      tick();
      if (cyc < 38 && rif.rec_valid !== 1'b0) bad++;
      if (win_start_o !== (cyc == 32)) bad++;
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL first_window_quiet got %0d exp 0 violations", bad); end
    checks++; if (win_cnt_o !== 16'd1) begin errors++; $display("FAIL basic_wincnt got %0d exp 1", win_cnt_o); end
    for (int i = 0; i < NC; i++) begin
      checks++; if (rif.rec_valid !== 1'b1) begin errors++; $display("FAIL basic_valid%0d got %b exp 1", i, rif.rec_valid); end
      checks++; if (rif.rec_core !== 2'(i)) begin errors++; $display("FAIL basic_core%0d got %0d exp %0d", i, rif.rec_core, i); end
      checks++; if (rif.rec_max !== lanes[i]) begin errors++; $display("FAIL basic_max%0d got %0d exp %0d", i, rif.rec_max, lanes[i]); end
      checks++; if (rif.rec_last !== (i == NC - 1)) begin errors++; $display("FAIL basic_last%0d got %b", i, rif.rec_last); end
      checks++; if (peak_o !== 8'd0) begin errors++; $display("FAIL basic_partial_peak%0d got %0d exp 0", i, peak_o); end
`ifdef ADC_MAX_OVR_FLAG_EN
      checks++; if (rif.rec_ovr !== (lanes[i] >= 8'd100)) begin errors++; $display("FAIL ovr_flag%0d got %b", i, rif.rec_ovr); end
`endif
      tick();
    end
    checks++; if (rif.rec_valid !== 1'b0) begin errors++; $display("FAIL basic_done_valid got %b exp 0", rif.rec_valid); end
    checks++; if (peak_o !== 8'd200) begin errors++; $display("FAIL basic_peak got %0d exp 200", peak_o); end
`ifdef ADC_MAX_OVR_FLAG_EN
    checks++; if (ovr_win_cnt_o !== 16'd1) begin errors++; $display("FAIL ovr_win_cnt got %0d exp 1", ovr_win_cnt_o); end
`endif
  endtask

  task automatic test_ready_toggle();
    int acc = 0;
    int exp_idx = 0;
    set_lanes(8'd30, 8'd90, 8'd150, 8'd60);
    wait_to(70);
    checks++; if (win_cnt_o !== 16'd2) begin errors++; $display("FAIL toggle_wincnt got %0d exp 2", win_cnt_o); end
    for (int c = 0; c < 20 && acc < 4; c++) begin
      checks++; if (rif.rec_valid !== 1'b1) begin errors++; $display("FAIL toggle_valid c%0d got %b exp 1", c, rif.rec_valid); end
      checks++; if (rif.rec_core !== 2'(exp_idx)) begin errors++; $display("FAIL toggle_core c%0d got %0d exp %0d", c, rif.rec_core, exp_idx); end
      checks++; if (rif.rec_max !== lanes[exp_idx]) begin errors++; $display("FAIL toggle_max c%0d got %0d exp %0d", c, rif.rec_max, lanes[exp_idx]); end
      checks++; if (peak_o !== 8'd200) begin errors++; $display("FAIL toggle_hold_peak c%0d got %0d exp 200", c, peak_o); end
      rif.rec_ready = c[0];
      tick();
      if (rif.rec_ready) begin
        acc++;
        exp_idx++;
      end
    end
    rif.rec_ready = 1'b1;
    checks++; if (acc !== 4) begin errors++; $display("FAIL toggle_accepts got %0d exp 4", acc); end
    checks++; if (rif.rec_valid !== 1'b0) begin errors++; $display("FAIL toggle_done_valid got %b exp 0", rif.rec_valid); end
    checks++; if (peak_o !== 8'd150) begin errors++; $display("FAIL toggle_peak got %0d exp 150", peak_o); end
  endtask

  task automatic test_overrun();
    set_lanes(8'd1, 8'd2, 8'd3, 8'd4);
    rif.rec_ready = 1'b0;
    wait_to(102);
    checks++; if (rif.rec_valid !== 1'b1 || rif.rec_max !== 8'd1) begin errors++; $display("FAIL ovr_scan_start valid %b max %0d exp 1/1", rif.rec_valid, rif.rec_max); end
    checks++; if (win_cnt_o !== 16'd3) begin errors++; $display("FAIL ovr_wincnt3 got %0d exp 3", win_cnt_o); end
    checks++; if (overrun_o !== 1'b0) begin errors++; $display("FAIL ovr_early got %b exp 0", overrun_o); end
    set_lanes(8'd99, 8'd99, 8'd99, 8'd99);
    wait_to(142);
    checks++; if (overrun_o !== 1'b1) begin errors++; $display("FAIL overrun_set got %b exp 1", overrun_o); end
    checks++; if (win_cnt_o !== 16'd4) begin errors++; $display("FAIL ovr_wincnt4 got %0d exp 4", win_cnt_o); end
    checks++; if (rif.rec_core !== 2'd0) begin errors++; $display("FAIL ovr_core_held got %0d exp 0", rif.rec_core); end
    rif.rec_ready = 1'b1;
    for (int i = 0; i < NC; i++) begin
      checks++; if (rif.rec_max !== 8'(i + 1)) begin errors++; $display("FAIL ovr_bank_kept%0d got %0d exp %0d", i, rif.rec_max, i + 1); end
      tick();
    end
    checks++; if (peak_o !== 8'd4) begin errors++; $display("FAIL ovr_peak got %0d exp 4", peak_o); end
    checks++; if (rif.rec_valid !== 1'b0) begin errors++; $display("FAIL ovr_done_valid got %b exp 0", rif.rec_valid); end
    clr_i = 1'b1;
    tick();
    clr_i = 1'b0;
    checks++; if (overrun_o !== 1'b0) begin errors++; $display("FAIL overrun_clr got %b exp 0", overrun_o); end
  endtask

  task automatic test_en_low();
    int bad = 0;
    wait_to(166);
    checks++; if (rif.rec_valid !== 1'b1 || rif.rec_max !== 8'd99) begin errors++; $display("FAIL en_scan valid %b max %0d exp 1/99", rif.rec_valid, rif.rec_max); end
    checks++; if (win_cnt_o !== 16'd5) begin errors++; $display("FAIL en_wincnt5 got %0d exp 5", win_cnt_o); end
    tick();
    en_i = 1'b0;
    wait_to(170);
    checks++; if (rif.rec_valid !== 1'b0) begin errors++; $display("FAIL en_drain_valid got %b exp 0", rif.rec_valid); end
    checks++; if (peak_o !== 8'd99) begin errors++; $display("FAIL en_drain_peak got %0d exp 99", peak_o); end
    while (cyc < 180) begin
      tick();
      if (win_start_o !== 1'b0) bad++;
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL en_low_strobe got %0d exp 0 strobes", bad); end
    set_lanes(8'd5, 8'd5, 8'd5, 8'd5);
    en_i = 1'b1;
    #1;
    checks++; if (win_start_o !== 1'b1) begin errors++; $display("FAIL en_rise_strobe got %b exp 1", win_start_o); end
    wait_to(190);
    checks++; if (win_cnt_o !== 16'd5 || rif.rec_valid !== 1'b0) begin errors++; $display("FAIL en_partial_skip wincnt %0d valid %b exp 5/0", win_cnt_o, rif.rec_valid); end
    wait_to(218);
    checks++; if (rif.rec_valid !== 1'b1 || rif.rec_max !== 8'd5) begin errors++; $display("FAIL en_resume valid %b max %0d exp 1/5", rif.rec_valid, rif.rec_max); end
    checks++; if (win_cnt_o !== 16'd6) begin errors++; $display("FAIL en_wincnt6 got %0d exp 6", win_cnt_o); end
  endtask

  task automatic test_reset_mid_scan();
    wait_to(220);
    checks++; if (rif.rec_core !== 2'd2) begin errors++; $display("FAIL rst_scan_idx got %0d exp 2", rif.rec_core); end
    rst_n = 1'b0;
    #1;
    checks++; if (rif.rec_valid !== 1'b0) begin errors++; $display("FAIL rst_async_valid got %b exp 0", rif.rec_valid); end
    checks++; if (peak_o !== 8'd0) begin errors++; $display("FAIL rst_async_peak got %0d exp 0", peak_o); end
    checks++; if (win_cnt_o !== 16'd0) begin errors++; $display("FAIL rst_async_wincnt got %0d exp 0", win_cnt_o); end
    en_i = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    rif.rec_ready = 1'b1;
    test_reset();
    test_basic();
    test_ready_toggle();
    test_overrun();
    test_en_low();
    test_reset_mid_scan();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
